body_mem_loader: RTL and testbench

- Writer side of the body-state BRAM (ram_2_port write port: wraddress/data/wren). NBodySim and the benches read body records from that memory; this block fills it.
- Accepts a 16-bit halfword stream over a valid/ready handshake and packs each 5 halfwords into one 80-bit body record.
- Writes N records to consecutive addresses starting at a base address, then pulses done so NBodySim can be started.

---
 rtl/nbody_pkg.sv | 25 ++
 rtl/body_mem_loader_packer.sv | 40 ++++
 rtl/body_mem_loader.sv | 113 +++++++++++
 tb/tb_body_mem_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbody_pkg.sv
// Shared types and constants for the N-body body-state memory path.
// A body record is five signed 16-bit fixed-point fields packed into 80 bits.
package nbody_pkg;

  localparam int REC_W  = 80;
  localparam int HW_W   = 16;
  localparam int BEATS  = REC_W / HW_W;
  localparam int BEAT_W = 3;

  typedef struct packed {
    logic signed [HW_W-1:0] x;
    logic signed [HW_W-1:0] y;
    logic signed [HW_W-1:0] vx;
    logic signed [HW_W-1:0] vy;
    logic signed [HW_W-1:0] mass;
  } body_rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/body_mem_loader_packer.sv
// Gathers five halfwords (MSB halfword first) into one body record.
// rec_valid is combinational and marks the transfer that completes a record.
module halfword_packer
  import nbody_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [HW_W-1:0] in_data,
  input  logic            in_fire,
  output logic            rec_valid,
  output body_rec_t       record
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [REC_W-1:0]  shift_q, shift_d;

  always_comb begin
    beat_d  = beat_q;
    shift_d = shift_q;
    if (in_fire) begin
      shift_d = {shift_q[REC_W-HW_W-1:0], in_data};
      beat_d  = (beat_q == BEAT_W'(BEATS - 1)) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // The completing beat is not registered yet, so it is spliced in here.
  assign rec_valid = in_fire && (beat_q == BEAT_W'(BEATS - 1));
  assign record    = body_rec_t'({shift_q[REC_W-HW_W-1:0], in_data});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q  <= '0;
      shift_q <= '0;
    end else begin
      beat_q  <= beat_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/body_mem_loader.sv
// Fills the body-state BRAM write port with N packed records from a halfword
// stream, starting at a latched base address, then pulses done.
module body_mem_loader
  import nbody_pkg::*;
#(
  parameter int N      = 2,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [HW_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [REC_W-1:0]  data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output state_e            state_dbg
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_REC = CNT_W'((N > 0) ? N - 1 : 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic              wren_q, wren_d;
  logic [REC_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;

  logic      in_fire;
  logic      rec_valid;
  body_rec_t record;

  // Handshake: a halfword moves on a cycle where in_valid && in_ready; in_ready
  // depends only on state, and in_valid without in_ready leaves everything as is.
  assign in_ready = (state_q == LOAD);
  assign in_fire  = in_valid && in_ready;

  halfword_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_fire   (in_fire),
    .rec_valid (rec_valid),
    .record    (record)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rec_cnt_d   = rec_cnt_q;
    wren_d      = 1'b0;
    data_d      = data_q;
    wraddress_d = wraddress_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          rec_cnt_d = '0;
          state_d   = (N == 0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (rec_valid) begin
          wren_d      = 1'b1;
          data_d      = record;
          wraddress_d = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          if (rec_cnt_q == LAST_REC) begin
            rec_cnt_d = '0;
            state_d   = FLUSH;
          end else begin
            rec_cnt_d = rec_cnt_q + CNT_W'(1);
          end
        end
      end
      // The final record's write cycle; the stream is already closed.
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rec_cnt_q   <= '0;
      wren_q      <= 1'b0;
      data_q      <= '0;
      wraddress_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rec_cnt_q   <= rec_cnt_d;
      wren_q      <= wren_d;
      data_q      <= data_d;
      wraddress_q <= wraddress_d;
    end
  end

  assign wren      = wren_q;
  assign data      = data_q;
  assign wraddress = wraddress_q;
  assign busy      = (state_q == LOAD) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_body_mem_loader.sv
// Bench for body_mem_loader: random halfword streams against a record/address
// model, plus a second instance built with N=0.
module tb_body_mem_loader;
  import nbody_pkg::*;

  localparam int N  = 2;
  localparam int AW = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   in_data = '0;
  logic          in_ready, wren, busy, done;
  logic [AW-1:0] wraddress;
  logic [79:0]   data;
  state_e        state_dbg;

  logic          start0 = 1'b0;
  logic          in_ready0, wren0, busy0, done0;
  logic [AW-1:0] wraddress0;
  logic [79:0]   data0;
  state_e        state_dbg0;

  body_mem_loader #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wraddress(wraddress), .data(data), .wren(wren), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  body_mem_loader #(.N(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .base_addr(base_addr),
    .in_data(in_data), .in_valid(1'b1), .in_ready(in_ready0),
    .wraddress(wraddress0), .data(data0), .wren(wren0), .busy(busy0),
    .done(done0), .state_dbg(state_dbg0)
  );

  // ---------------- scoreboard state ----------------
  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]   hw_q[$];
  int            beat_cyc_q[$];
  logic [79:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [79:0]   obs_data_q[$];
  logic [AW-1:0] obs_addr_q[$];
  int            obs_cyc_q[$];
  int done_cnt = 0, done_cyc = 0;
  int wren0_cnt = 0, done0_cnt = 0, rdy0_cnt = 0, done0_cyc = 0;

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      obs_addr_q.push_back(wraddress);
      obs_data_q.push_back(data);
      obs_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (wren0 === 1'b1) wren0_cnt++;
    if (in_ready0 === 1'b1) rdy0_cnt++;
    if (done0 === 1'b1) begin done0_cnt++; done0_cyc = cyc; end
  end

  // ---------------- model ----------------
  task automatic build_expected(input logic [AW-1:0] b);
    logic [79:0] rec;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < N; i++) begin
      rec = '0;
      for (int j = 0; j < BEATS; j++) rec = (rec << 16) | 80'(hw_q[i*BEATS+j]);
      exp_q.push_back(rec);
      exp_addr_q.push_back(AW'((int'(b) + i) % (1 << AW)));
    end
  endtask

  task automatic gen_hw(input bit counting);
    hw_q.delete();
    for (int i = 0; i < N * BEATS; i++)
      hw_q.push_back(counting ? 16'(i + 1) : 16'($urandom_range(0, 16'hFFFF)));
  endtask

  task automatic clear_obs();
    obs_addr_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
    done_cnt = 0;
  endtask

  // ---------------- drivers (called at a negedge) ----------------
  task automatic do_start(input logic [AW-1:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0; base_addr = AW'($urandom);
  endtask

  task automatic drive_stream(input int gap_beat, input int gap_len, input bit rand_gaps,
                              input int poke_beat);
    beat_cyc_q.delete();
    for (int i = 0; i < hw_q.size(); i++) begin
      int g; bit got; int w;
      g = 0;
      if (i == gap_beat) g = gap_len;
      else if (rand_gaps && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
      in_valid = 1'b1; in_data = hw_q[i];
      if (i == poke_beat) begin start = 1'b1; base_addr = 15'h100; end
      got = 1'b0; w = 0;
      while (!got && w < 20) begin
        got = in_ready;
        if (got) beat_cyc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        w++;
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL stream_timeout beat=%0d in_ready=%b required=1", i, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while (done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s_done_timeout done=%b required=1", name, done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if ({in_ready, wren, busy, done} !== 4'b0000) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {in_ready, wren, busy, done}); end
    total++; if (wraddress !== '0) begin bad++;
      $display("FAIL reset_wraddress got=%h exp=0", wraddress); end
    total++; if (data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
    total++; if (state_dbg !== IDLE) begin bad++;
      $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
  endtask

  task automatic test_basic();
    clear_obs(); gen_hw(1'b1); build_expected('0);
    do_start('0);
    drive_stream(-1, 0, 1'b0, -1);
    wait_done("basic");
    start = 1'b1; base_addr = 15'h55;   // start during DONE must be ignored
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (obs_data_q.size() != N) begin bad++;
      $display("FAIL basic_wren_count got=%0d exp=%0d", obs_data_q.size(), N); end
    for (int i = 0; i < N && i < obs_data_q.size(); i++) begin
      total++; if (obs_addr_q[i] !== exp_addr_q[i]) begin bad++;
        $display("FAIL basic_addr%0d got=%h exp=%h", i, obs_addr_q[i], exp_addr_q[i]); end
      total++; if (obs_data_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL basic_data%0d got=%h exp=%h", i, obs_data_q[i], exp_q[i]); end
      total++; if (obs_cyc_q[i] != beat_cyc_q[i*BEATS+4] + 1) begin bad++;
        $display("FAIL basic_latency%0d got=%0d exp=%0d", i, obs_cyc_q[i], beat_cyc_q[i*BEATS+4] + 1); end
    end
    total++; if (beat_cyc_q.size() == N*BEATS && beat_cyc_q[N*BEATS-1] - beat_cyc_q[0] != N*BEATS-1) begin
      bad++; $display("FAIL basic_streaming span=%0d exp=%0d",
                      beat_cyc_q[N*BEATS-1] - beat_cyc_q[0], N*BEATS-1); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    if (obs_cyc_q.size() == N) begin
      total++; if (done_cyc != obs_cyc_q[N-1] + 1) begin bad++;
        $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, obs_cyc_q[N-1] + 1); end
    end
    total++; if ({busy, in_ready} !== 2'b00 || state_dbg !== IDLE) begin bad++;
      $display("FAIL basic_start_in_done busy,in_ready=%b state=%0d exp=00,IDLE", {busy, in_ready}, state_dbg); end
  endtask

  task automatic test_gaps();
    clear_obs(); gen_hw(1'b1); build_expected('0);
    do_start('0);
    drive_stream(3, 3, 1'b0, -1);
    wait_done("gaps");
    repeat (2) @(negedge clk);
    total++; if (obs_data_q.size() != N) begin bad++;
      $display("FAIL gaps_wren_count got=%0d exp=%0d", obs_data_q.size(), N); end
    for (int i = 0; i < N && i < obs_data_q.size(); i++) begin
      total++; if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL gaps_rec%0d got=%h@%h exp=%h@%h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], exp_addr_q[i]); end
      total++; if (obs_cyc_q[i] != beat_cyc_q[i*BEATS+4] + 1) begin bad++;
        $display("FAIL gaps_latency%0d got=%0d exp=%0d", i, obs_cyc_q[i], beat_cyc_q[i*BEATS+4] + 1); end
    end
  endtask

  task automatic test_wrap();
    clear_obs(); gen_hw(1'b0); build_expected(15'h7FFF);
    do_start(15'h7FFF);
    drive_stream(-1, 0, 1'b1, -1);
    wait_done("wrap");
    repeat (2) @(negedge clk);
    total++; if (obs_data_q.size() != N) begin bad++;
      $display("FAIL wrap_wren_count got=%0d exp=%0d", obs_data_q.size(), N); end
    for (int i = 0; i < N && i < obs_data_q.size(); i++) begin
      total++; if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL wrap_rec%0d got=%h@%h exp=%h@%h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], exp_addr_q[i]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [AW-1:0] b;
    b = AW'($urandom_range(16'h200, 16'h7000));
    clear_obs(); gen_hw(1'b0); build_expected(b);
    do_start(b);
    drive_stream(-1, 0, 1'b1, 3);
    wait_done("start_ign");
    repeat (2) @(negedge clk);
    total++; if (obs_data_q.size() != N) begin bad++;
      $display("FAIL start_ign_wren_count got=%0d exp=%0d", obs_data_q.size(), N); end
    for (int i = 0; i < N && i < obs_data_q.size(); i++) begin
      total++; if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL start_ign_rec%0d got=%h@%h exp=%h@%h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], exp_addr_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0]   full_q[$];
    logic [AW-1:0] b;
    b = AW'($urandom_range(0, 16'h7FFF));
    clear_obs(); gen_hw(1'b0); full_q = hw_q;
    hw_q = full_q[0:2];
    do_start(b);
    drive_stream(-1, 0, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({in_ready, wren, busy, done} !== 4'b0000 || wraddress !== '0 || data !== '0) begin bad++;
      $display("FAIL rstmid_outputs ctrl=%b addr=%h data=%h exp=0", {in_ready, wren, busy, done}, wraddress, data); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (obs_data_q.size() != 0 || in_ready !== 1'b0) begin bad++;
      $display("FAIL rstmid_no_write writes=%0d in_ready=%b exp=0,0", obs_data_q.size(), in_ready); end
    hw_q = full_q; build_expected(b);
    do_start(b);
    drive_stream(-1, 0, 1'b0, -1);
    wait_done("rstmid");
    repeat (2) @(negedge clk);
    total++; if (obs_data_q.size() != N) begin bad++;
      $display("FAIL rstmid_wren_count got=%0d exp=%0d", obs_data_q.size(), N); end
    for (int i = 0; i < N && i < obs_data_q.size(); i++) begin
      total++; if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL rstmid_rec%0d got=%h@%h exp=%h@%h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], exp_addr_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    for (int t = 0; t < 6; t++) begin
      b = AW'($urandom_range(0, 16'h7FFF));
      clear_obs(); gen_hw(1'b0); build_expected(b);
      do_start(b);
      drive_stream(-1, 0, 1'b1, -1);
      wait_done("random");
      repeat ($urandom_range(1, 3)) @(negedge clk);
      total++; if (obs_data_q.size() != N || done_cnt != 1) begin bad++;
        $display("FAIL random%0d_counts writes=%0d done=%0d exp=%0d,1", t, obs_data_q.size(), done_cnt, N); end
      for (int i = 0; i < N && i < obs_data_q.size(); i++) begin
        total++; if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin bad++;
          $display("FAIL random%0d_rec%0d got=%h@%h exp=%h@%h", t, i, obs_data_q[i], obs_addr_q[i], exp_q[i], exp_addr_q[i]); end
      end
    end
  endtask

  task automatic test_n0();
    int s;
    wren0_cnt = 0; done0_cnt = 0; rdy0_cnt = 0;
    s = cyc;
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (done0_cnt != 1) begin bad++; $display("FAIL n0_done_count got=%0d exp=1", done0_cnt); end
    total++; if (done0_cyc - s < 1 || done0_cyc - s > 2) begin bad++;
      $display("FAIL n0_done_delay got=%0d exp=1..2", done0_cyc - s); end
    total++; if (wren0_cnt != 0 || rdy0_cnt != 0) begin bad++;
      $display("FAIL n0_quiet wren=%0d in_ready=%0d exp=0,0", wren0_cnt, rdy0_cnt); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_n0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
